sprite_rom_arbiter: RTL

- Shares one single-port sprite ROM (e.g. the character sprite ROM, 50x50 px, 3-bit palette index) between several pixel-fetch requesters: Fireboy renderer, Watergirl renderer, HUD/icon renderer.
- Round-robin arbitration with an optional strict-priority override for requester 0.
- Drives the ROM address from a register and routes the returned palette index back to the requester that issued it.
- Fully pipelined: one grant per cycle, fixed 2-cycle request-to-response latency.

---
 rtl/sprite_rom_arbiter_if.sv | 27 ++
 rtl/sprite_rom_arbiter.sv | 98 +++++++++
 2 files changed

// File: rtl/sprite_rom_arbiter_if.sv
// Request/response bundle between the pixel-fetch requesters, the arbiter and the sprite ROM.
// The slave modport is the arbiter view; the master modport is the requester/ROM side.
interface sprite_rom_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 3
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      prio_lock;
    logic [ADDR_W-1:0]         rom_addr;
    logic [DATA_W-1:0]         rom_q;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      busy;

    modport master (
        output req_valid, req_addr, prio_lock, rom_q,
        input  req_ready, rom_addr, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_addr, prio_lock, rom_q,
        output req_ready, rom_addr, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Round-robin (optional strict prio for req 0) sharing of one sprite ROM; one grant/cycle, 2-cycle latency.
// Grant is combinational via req_ready; responses have no backpressure and must be taken when strobed.
module sprite_rom_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 3
) (
    input logic                 vga_clk,
    input logic                 reset_n,
    sprite_rom_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int IW    = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;

    ptr_t               rr_ptr_q, rr_ptr_d;
    ptr_t               gnt_idx;
    logic               gnt_vld;
    logic [NUM_REQ-1:0] ready;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic               s1_valid_q, s1_valid_d;
    ptr_t               s1_tag_q, s1_tag_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;

    // Scan from the far end so the requester closest to rr_ptr is the last writer and wins.
    always_comb begin : arb
        logic [IW-1:0] idx;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        if (bus.prio_lock && bus.req_valid[0]) begin
            gnt_vld = 1'b1;
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                idx = {1'b0, rr_ptr_q} + IW'(k);
                if (idx >= IW'(NUM_REQ)) begin
                    idx = idx - IW'(NUM_REQ);
                end
                if (bus.req_valid[idx[PTR_W-1:0]]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = idx[PTR_W-1:0];
                end
            end
        end
    end

    always_comb begin
        ready = '0;
        if (gnt_vld) begin
            ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        rom_addr_d  = rom_addr_q;
        s1_valid_d  = gnt_vld;
        s1_tag_d    = s1_tag_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        if (gnt_vld) begin
            rr_ptr_d   = (gnt_idx == ptr_t'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            rom_addr_d = bus.req_addr[gnt_idx*ADDR_W +: ADDR_W];
            s1_tag_d   = gnt_idx;
        end
        // ROM sampled rom_addr on the intervening negedge, so rom_q belongs to the stage-1 request.
        if (s1_valid_q) begin
            rsp_valid_d[s1_tag_q] = 1'b1;
            rsp_data_d            = bus.rom_q;
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q    <= '0;
            rom_addr_q  <= '0;
            s1_valid_q  <= 1'b0;
            s1_tag_q    <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rom_addr_q  <= rom_addr_d;
            s1_valid_q  <= s1_valid_d;
            s1_tag_q    <= s1_tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus.req_ready = ready;
    assign bus.rom_addr  = rom_addr_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.busy      = s1_valid_q | (|rsp_valid_q);
endmodule
